// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: byte-wide configuration loader that serializes bytes LSB-first into the PAL fabric.
// Ports:
//   CLK          clock, all state on rising edge
//   RES_N        asynchronous active-low reset
//   START_I      one-cycle pulse, begin or restart a load
//   DIN_I        configuration byte, bit 0 shifted first
//   DIN_VALID_I  DIN_I holds a valid byte
//   DIN_READY_O  byte accepted this cycle when valid
//   CFG_O        serial configuration bit
//   SHIFT_O      CFG_O valid, fabric shifts one bit
//   APPLY_O      configuration committed (fabric enable)
//   BUSY_O       load in progress
//   DONE_O       one-cycle pulse after the last bit
//   BIT_CNT_O    bits shifted so far in the current load
module pal_cfg_loader #(
    parameter int N        = 8,
    parameter int M        = 4,
    parameter int P        = 14,
    parameter int CFG_BITS = 2*N*P + P*M,
    parameter int CNT_W    = $clog2(CFG_BITS+1)
) (
    input  logic             CLK,
    input  logic             RES_N,
    input  logic             START_I,
    input  logic [7:0]       DIN_I,
    input  logic             DIN_VALID_I,
    output logic             DIN_READY_O,
    output logic             CFG_O,
    output logic             SHIFT_O,
    output logic             APPLY_O,
    output logic             BUSY_O,
    output logic             DONE_O,
    output logic [CNT_W-1:0] BIT_CNT_O
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t state, state_d;
    logic [7:0]       sreg;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept, last;
    assign DIN_READY_O = state == LOAD;
    assign SHIFT_O     = state == SHIFT;
    assign BUSY_O      = state != IDLE;
    // the captured byte shifts right each cycle, so bit 0 is always the current bit
    assign CFG_O       = SHIFT_O & sreg[0];
    always_comb begin
        cnt_inc = BIT_CNT_O + CNT_W'(1);
        accept  = state == LOAD && DIN_VALID_I;
        last    = state == SHIFT && cnt_inc == CNT_W'(CFG_BITS);
        state_d = state;
        // START overrides everything, including the terminal shift
        if (START_I)
            state_d = LOAD;
        else if (accept)
            state_d = SHIFT;
        else if (last)
            state_d = IDLE;
        else if (state == SHIFT && idx == 3'd7)
            state_d = LOAD;
    end
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state     <= IDLE;
            sreg      <= '0;
            idx       <= '0;
            BIT_CNT_O <= '0;
            APPLY_O   <= 1'b0;
            DONE_O    <= 1'b0;
        end else begin
            state  <= state_d;
            DONE_O <= last && !START_I;
            if (START_I) begin
                sreg      <= '0;
                idx       <= '0;
                BIT_CNT_O <= '0;
                APPLY_O   <= 1'b0;
            end else if (accept) begin
                sreg <= DIN_I;
                idx  <= '0;
            end else if (state == SHIFT) begin
                sreg      <= sreg >> 1;
                idx       <= idx + 3'd1;
                BIT_CNT_O <= cnt_inc;
                if (last)
                    APPLY_O <= 1'b1;
            end
        end
    end
endmodule

// File: doc/pal_cfg_loader.md
Name: pal_cfg_loader

Overview:
- Byte-wide configuration loader for the PAL fabric.
- Accepts configuration bytes over a valid/ready interface and serializes them LSB-first onto the PAL's 1-bit configuration input, with a per-bit shift strobe.
- Counts exactly CFG_BITS bits, then asserts the apply/enable level that commits the configuration to the fabric.
- Sits between the chip IO (or a host interface) and the PAL instance; replaces bit-banging CFG/EN from pins.

Parameters:
- N, 8, number of PAL inputs
- M, 4, number of PAL outputs
- P, 14, number of intermediate (product-term) stages
- CFG_BITS, 2*N*P + P*M (280 at defaults), total configuration bits to shift
- CNT_W, $clog2(CFG_BITS+1), width of the bit counter

Ports:
- CLK  input  1  clock; all state on rising edge
- RES_N  input  1  asynchronous active-low reset
- START_I  input  1  one-cycle pulse; begin (or restart) a configuration load
- DIN_I  input  8  configuration byte; bit 0 is shifted first
- DIN_VALID_I  input  1  DIN_I holds a valid byte
- DIN_READY_O  output  1  loader accepts a byte this cycle
- CFG_O  output  1  serial config bit to PAL CFG
- SHIFT_O  output  1  CFG_O valid; PAL shifts one bit this cycle
- APPLY_O  output  1  level to PAL EN; configuration committed
- BUSY_O  output  1  load in progress (LOAD or SHIFT)
- DONE_O  output  1  one-cycle pulse when the last bit has been shifted
- BIT_CNT_O  output  CNT_W  bits shifted so far in the current load

Behaviour:
- Reset (async, RES_N=0):
  - state=IDLE
  - DIN_READY_O=0, CFG_O=0, SHIFT_O=0, APPLY_O=0, BUSY_O=0, DONE_O=0, BIT_CNT_O=0
  - Shift register cleared.
  - Reset mid-load aborts with no further SHIFT_O pulses.
- States: IDLE, LOAD, SHIFT.
- IDLE:
  - DIN_READY_O=0; DIN_VALID_I is ignored.
  - START_I=1 -> LOAD next cycle, BIT_CNT_O<=0, APPLY_O<=0.
- LOAD:
  - DIN_READY_O=1, BUSY_O=1.
  - On DIN_VALID_I & DIN_READY_O: capture DIN_I, byte bit index<=0, go to SHIFT.
  - Otherwise stay (stall indefinitely, no timeout).
- SHIFT:
  - DIN_READY_O=0, BUSY_O=1, SHIFT_O=1.
  - CFG_O = captured byte bit[index] (registered output, valid in the same cycle as SHIFT_O).
  - Each cycle: index+1, BIT_CNT_O+1.
  - After bit 7 with BIT_CNT_O+1 < CFG_BITS -> LOAD.
  - When BIT_CNT_O+1 == CFG_BITS -> IDLE immediately, even mid-byte. Remaining bits of the final byte are discarded.
  - On that terminal transition: DONE_O=1 for exactly one cycle (the cycle after the last SHIFT_O), APPLY_O<=1 from the same cycle.
  - APPLY_O holds until the next START_I or reset.
- Timing:
  - Byte throughput: 1 accept cycle + 8 shift cycles = 9 cycles per full byte.
  - Full load at defaults: 35 bytes, 280 SHIFT_O cycles.
  - SHIFT_O is never high in IDLE or LOAD; CFG_O=0 whenever SHIFT_O=0.
- START_I while BUSY_O=1 (LOAD or SHIFT):
  - Abort; next cycle state=LOAD, BIT_CNT_O=0, SHIFT_O=0.
  - Captured byte discarded; APPLY_O stays 0.
- START_I in the same cycle as the terminal shift:
  - START wins: no DONE_O, APPLY_O=0, restart in LOAD.
- START_I while IDLE with APPLY_O=1: APPLY_O drops the next cycle (fabric disabled during reload).
- Counter width: BIT_CNT_O never exceeds CFG_BITS; no wrap.

Test Plan:
- Nominal load at defaults: START, then 35 bytes 0xA5 with DIN_VALID_I held high -> 280 SHIFT_O cycles; CFG_O pattern 1,0,1,0,0,1,0,1 repeating; BIT_CNT_O=280; DONE_O single pulse; APPLY_O=1 afterwards; total 315 cycles from first accept.
- Backpressure/stall: deassert DIN_VALID_I for 5 cycles between bytes 3 and 4 -> loader holds LOAD with DIN_READY_O=1, no SHIFT_O, BIT_CNT_O frozen at 24; the captured stream is identical to the nominal run.
- Partial final byte: CFG_BITS=20; bytes 0xFF,0x00,0x0F -> exactly 20 SHIFT_O; last four CFG_O=1; bits 4..7 of the third byte are never shifted; DONE_O follows bit 20.
- Abort: START again after 100 bits -> SHIFT_O drops next cycle, BIT_CNT_O=0, APPLY_O=0; a full reload then completes normally.
- Reload disables the fabric: with APPLY_O=1, pulse START -> APPLY_O=0 next cycle and remains 0 until the new DONE_O.
- Async reset mid-SHIFT: RES_N low for 2 cycles during byte 10 -> all outputs 0 immediately; no SHIFT_O after release; DIN_VALID_I is ignored until START.
